// File: rtl/micro_sequencer.sv
// micro_sequencer: registered microprogram sequencer.
// Holds the micro-PC and picks the next microaddress from the microword
// next-address field, opcode dispatch, a LIFO return stack, or upc+1.
// Optional loop counter (modes 4/5) is built when MSEQ_LOOP_EN is defined;
// otherwise modes 4-7 all behave as SEQ.
module micro_sequencer #(
   parameter int AW           = 5,
   parameter int FETCH_ADDR   = 0,
   parameter int JMPNZ_Y_ADDR = 9,
   parameter int JMPNZ_N_ADDR = 11,
   parameter int DEPTH        = 4
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       en,
   input  logic [2:0]                 mode,
   input  logic [AW-1:0]              na,
   input  logic [AW-1:0]              ir,
   input  logic                       z,
   output logic [AW-1:0]              upc,
   output logic [$clog2(DEPTH+1)-1:0] depth,
   output logic                       err
);

   localparam int DW = $clog2(DEPTH + 1);
   localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   localparam logic [AW-1:0] FETCH     = AW'(FETCH_ADDR);
   localparam logic [AW-1:0] JMPNZ_Y   = AW'(JMPNZ_Y_ADDR);
   localparam logic [AW-1:0] JMPNZ_N   = AW'(JMPNZ_N_ADDR);
   localparam logic [DW-1:0] DEPTH_MAX = DW'(DEPTH);

   typedef enum logic [2:0] {
      M_SEQ      = 3'd0,
      M_DISPATCH = 3'd1,
      M_CALL     = 3'd2,
      M_RET      = 3'd3,
      M_LDCNT    = 3'd4,
      M_LOOP     = 3'd5,
      M_RSV6     = 3'd6,
      M_RSV7     = 3'd7
   } mode_e;

   logic [AW-1:0] upc_q, upc_d;
   logic [DW-1:0] depth_q, depth_d;
   logic          err_q, err_d;
   logic [AW-1:0] stack_q [DEPTH];
   logic [AW-1:0] stack_d [DEPTH];
   logic [AW-1:0] upc_inc;
   logic [IW-1:0] push_idx;
   logic [IW-1:0] pop_idx;
`ifdef MSEQ_LOOP_EN
   logic [AW-1:0] cnt_q, cnt_d;
`endif

   // Push goes to the slot just above the top; pop reads the top slot.
   // Both indices are only used when the occupancy makes them in range.
   always_comb begin
      upc_inc  = upc_q + AW'(1);
      push_idx = IW'(depth_q);
      pop_idx  = IW'(depth_q - DW'(1));
   end

   // Next-address selection and stack/error bookkeeping; stall holds all.
   always_comb begin
      upc_d   = upc_q;
      depth_d = depth_q;
      err_d   = err_q;
      stack_d = stack_q;
`ifdef MSEQ_LOOP_EN
      cnt_d   = cnt_q;
`endif
      if (en) begin
         case (mode_e'(mode))
            M_SEQ: upc_d = na;
            M_DISPATCH: begin
               // JMPNZ with zero set falls through to the not-taken path
               if (ir == JMPNZ_Y && z) upc_d = JMPNZ_N;
               else                    upc_d = ir;
            end
            M_CALL: begin
               // Overflowing call still jumps; only the return address is lost
               upc_d = na;
               if (depth_q == DEPTH_MAX) begin
                  err_d = 1'b1;
               end else begin
                  stack_d[push_idx] = upc_inc;
                  depth_d           = depth_q + DW'(1);
               end
            end
            M_RET: begin
               // Underflow recovers to instruction fetch
               if (depth_q == '0) begin
                  err_d = 1'b1;
                  upc_d = FETCH;
               end else begin
                  upc_d   = stack_q[pop_idx];
                  depth_d = depth_q - DW'(1);
               end
            end
`ifdef MSEQ_LOOP_EN
            M_LDCNT: begin
               cnt_d = na;
               upc_d = upc_inc;
            end
            M_LOOP: begin
               if (cnt_q != '0) begin
                  cnt_d = cnt_q - AW'(1);
                  upc_d = na;
               end else begin
                  upc_d = upc_inc;
               end
            end
`endif
            default: upc_d = na;
         endcase
      end
   end

   // State register with synchronous reset; stack contents need no reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         upc_q   <= FETCH;
         depth_q <= '0;
         err_q   <= 1'b0;
`ifdef MSEQ_LOOP_EN
         cnt_q   <= '0;
`endif
      end else begin
         upc_q   <= upc_d;
         depth_q <= depth_d;
         err_q   <= err_d;
`ifdef MSEQ_LOOP_EN
         cnt_q   <= cnt_d;
`endif
      end
      stack_q <= stack_d;
   end

   assign upc   = upc_q;
   assign depth = depth_q;
   assign err   = err_q;

endmodule

// File: doc/micro_sequencer.md
Name: micro_sequencer

Overview:
- Registered microprogram sequencer for the control unit; generalises the combinational next-address logic.
- Holds the micro-PC (upc) and selects the next microaddress each cycle from one of four sources: the microword next-address field (na), opcode dispatch (ir), a return stack, or upc+1.
- Supports the JMPNZ redirect, micro-subroutine call/return with a parametrised stack, a stall enable, and a sticky error flag.
- Sits between the control store (supplies na and mode) and the IR/ALU (supply ir and z).

Parameters:
AW, 5, microaddress width in bits (ir opcode is AW bits and maps directly to its first microstep)
FETCH_ADDR, 0, reset/recovery microaddress (FETCH1)
JMPNZ_Y_ADDR, 9, dispatch address of JMPNZ taken path (JMPNZY1)
JMPNZ_N_ADDR, 11, redirect address when z=1 at JMPNZ dispatch (JMPNZN1)
DEPTH, 4, return-stack entries (>=1)

Ports:
clk  input  1  clock, rising edge
reset  input  1  synchronous, active-high reset
en  input  1  advance enable; 0 = stall, all state held
mode  input  3  next-address mode from the current microword
na  input  AW  next-address field of the current microword
ir  input  AW  opcode field of the instruction register
z  input  1  ALU zero flag
upc  output  AW  current microaddress (registered)
depth  output  $clog2(DEPTH+1)  return-stack occupancy
err  output  1  sticky stack error flag

Behaviour:
- Reset: applied on a clk edge with reset=1, regardless of en. Sets upc=FETCH_ADDR, depth=0, err=0, stack contents don't-care. Reset mid-subroutine discards the stack.
- Latency: all state updates on the rising clk edge when en=1. upc reflects the selection one cycle after mode/na/ir/z are presented.
- en=0: upc, stack, depth, err and loop counter all held; mode is ignored.
- Address arithmetic is modulo 2^AW: upc+1 wraps from 2^AW-1 to 0.
- mode 0 SEQ: upc<=na. Stack unchanged.
- mode 1 DISPATCH:
  - If ir==JMPNZ_Y_ADDR and z==1: upc<=JMPNZ_N_ADDR.
  - Otherwise upc<=ir. z is ignored for any other ir value.
- mode 2 CALL: push (upc+1) and set upc<=na.
  - If depth==DEPTH (full): no push, depth unchanged, err<=1; the jump to na is still taken.
- mode 3 RET: upc<=top of stack, pop, depth-1.
  - If depth==0 (empty): err<=1, upc<=FETCH_ADDR, depth stays 0.
- modes 4-7: see Optional Feature. Modes 6 and 7 are always treated as SEQ.
- Stack is LIFO; depth counts 0..DEPTH.
- err stays set until reset.

Optional Feature:
- Macro: MSEQ_LOOP_EN.
- Defined:
  - Adds an AW-bit loop counter cnt, reset to 0.
  - mode 4 LDCNT: cnt<=na, upc<=upc+1.
  - mode 5 LOOP: if cnt!=0 then cnt<=cnt-1 and upc<=na; else upc<=upc+1 and cnt stays 0.
  - The counter holds under en=0.
- Undefined: no counter is instantiated; modes 4 and 5 behave exactly as SEQ (upc<=na) and err is unaffected.

Test Plan:
- Reset, then en=1: mode0 na=1 -> upc=1; mode1 ir=19 -> upc=19; mode0 na=20 -> upc=20; mode0 na=0 -> upc=0 (fetch/LOAD flow).
- Dispatch: mode1 ir=9 z=0 -> upc=9; mode1 ir=9 z=1 -> upc=11; mode1 ir=18 z=1 -> upc=18 (z ignored for non-JMPNZ).
- Stall: upc=5, en=0, mode0 na=7 for 3 cycles -> upc stays 5; raise en -> upc=7 next cycle. Reset asserted while en=0 -> upc=0.
- Call/return (DEPTH=4): upc=3, CALL na=24 -> upc=24, depth=1; CALL na=28 -> upc=28, depth=2; RET -> upc=25, depth=1; RET -> upc=4, depth=0, err=0.
- Errors: from depth=0, RET -> upc=0, err=1. After reset, 5 CALLs -> depth=4, err=1 on the 5th, upc=na of the 5th. Reset -> err=0, depth=0. Wrap: upc=31, CALL na=2, RET -> upc=0.
- MSEQ_LOOP_EN defined: upc=6, LDCNT na=2 -> upc=7; three LOOP na=7 -> upc 7, 7, then 8; cnt ends 0. Undefined: mode4 na=12 -> upc=12.
